pingpong_frame_buf: RTL and testbench
=====================================

PINGPONG_FRAME_BUF -- requirements
Module: pingpong_frame_buf

Interface
REQ-001 Parameters: DATA_WIDTH, default 18, sample width per channel; N_CH, default 2, channels (I/Q); MEM_DEPTH, default 1200, words per bank; ADDR_WIDTH, default 11, address width.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 wr_en  in  1  write strobe.
REQ-005 wr_addr  in  ADDR_WIDTH  write address within the current write bank.
REQ-006 wr_data  in  N_CH*DATA_WIDTH  channel 0 in LSBs.
REQ-007 wr_last  in  1  qualifies the wr_en beat as the final beat of a frame.
REQ-008 rd_ready  in  1  downstream accepts rd_data.
REQ-009 rd_valid  out  1  rd_data valid.
REQ-010 rd_data  out  N_CH*DATA_WIDTH  read word.
REQ-011 rd_addr  out  ADDR_WIDTH  address of the current rd_data word.
REQ-012 rd_last  out  1  current rd_data is the final word of a frame.
REQ-013 rd_done  out  1  one-cycle pulse after the final word is accepted.
REQ-014 bank_full  out  2  per-bank full flags.
REQ-015 overflow  out  1  sticky: a write was dropped because its bank was full.
REQ-016 addr_err  out  1  sticky: a write had wr_addr >= MEM_DEPTH.

Function
REQ-017 Two banks, each MEM_DEPTH x N_CH*DATA_WIDTH, with a synchronous read of latency 1.
REQ-018 Write side: wr_bank pointer starts at 0; a write is accepted when wr_en=1, bank_full[wr_bank]=0 and wr_addr<MEM_DEPTH.
REQ-019 Frame close: an accepted beat with wr_last=1 stores len[wr_bank]=wr_addr+1, sets bank_full[wr_bank] and toggles wr_bank on the next edge.
REQ-020 Blocked write: wr_en=1 while bank_full[wr_bank]=1 writes nothing and sets overflow; wr_last on a dropped beat is ignored.
REQ-021 Bad address: wr_en=1 with wr_addr>=MEM_DEPTH writes nothing and sets addr_err; if wr_last=1 on that beat, the frame still closes with len=MEM_DEPTH.
REQ-022 Read FSM states and transitions:
- IDLE -> FETCH when bank_full[rd_bank]=1; rd_bank starts at 0.
- FETCH: issues read address 0; -> STREAM next cycle.
- STREAM: rd_valid=1.
REQ-023 Latency: rd_valid rises 2 cycles after bank_full[rd_bank] rises.
REQ-024 STREAM handshake: a beat transfers when rd_valid&rd_ready=1. rd_data, rd_addr and rd_last stay stable while rd_valid=1 and rd_ready=0.
REQ-025 Back-to-back transfers: with rd_ready held at 1, one word is transferred per cycle with no bubbles inside a frame (read address prefetched).
REQ-026 rd_last=1 exactly when rd_addr=len[rd_bank]-1.
REQ-027 Final transfer of a frame:
- bank_full[rd_bank] clears and rd_bank toggles.
- rd_done pulses for 1 cycle on the next cycle.
- FSM -> FETCH if the other bank is full, else -> IDLE.
- Minimum gap between frames: 1 cycle.
REQ-028 Same-cycle release and write: if the reader releases the bank the writer is blocked on in the same cycle, the write is accepted and overflow is not set.
REQ-029 The writer closing a frame on one bank and the reader releasing the other bank in the same cycle both take effect.
REQ-030 Frames of length 1 (wr_last on wr_addr=0) produce a single beat with rd_last=1.
REQ-031 Words never written in a frame read back as their stale content; no zero fill.

Reset
REQ-032 On reset=0 (asynchronous):
- FSM=IDLE; wr_bank=0; rd_bank=0.
- bank_full=2'b00; len=0.
- rd_valid=0; rd_last=0; rd_done=0; rd_addr=0; rd_data=0.
- overflow=0; addr_err=0.
- Memory contents are not reset.
REQ-033 Reset asserted mid-frame discards both banks. After release the block waits in IDLE for a new frame.

Verification
REQ-034 Write 5 words to addresses 0..4 with data 0x11..0x15, wr_last on address 4; rd_ready=1 -> rd_valid rises 2 cycles after bank_full[0]; rd_data 0x11..0x15 on consecutive cycles; rd_last with rd_addr=4; rd_done 1 cycle later; bank_full=00.
REQ-035 Same frame with rd_ready toggling 1,0,0,1,... -> each word held stable through stalls; exactly 5 transfers; order preserved.
REQ-036 Fill bank 0 (len 4) and bank 1 (len 3) with rd_ready=0, then write again -> overflow=1, bank_full=11. Set rd_ready=1 -> 4 words from bank 0, 1-cycle gap, 3 words from bank 1.
REQ-037 wr_addr=MEM_DEPTH with wr_en=1 -> addr_err=1; memory unchanged. Single-beat frame at address 0 -> one beat with rd_last=1 and rd_done.
REQ-038 Writer blocked on bank 0 while the reader accepts bank 0's last word in the same cycle -> write accepted, overflow stays 0.
REQ-039 Assert reset mid-STREAM -> all outputs at reset values immediately, before the next clock edge; a subsequent 3-word frame reads out correctly.

Source files
------------

// File: rtl/pingpong_frame_buf.sv
// pingpong_frame_buf
//   Two-bank frame buffer. The writer fills one bank while the reader drains
//   the other. A frame is closed by wr_last, and the write pointer then moves
//   to the other bank. The reader streams each full bank from address 0 up to
//   len-1 with a valid/ready handshake, and then releases the bank.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-low reset
//   wr_en      : write strobe
//   wr_addr    : word address within the current write bank
//   wr_data    : N_CH samples, channel 0 in the LSBs
//   wr_last    : marks the wr_en beat as the final beat of a frame
//   rd_ready   : downstream accepts rd_data
//   rd_valid   : rd_data/rd_addr/rd_last are valid
//   rd_data    : read word
//   rd_addr    : address of the current rd_data word
//   rd_last    : current word is the final word of the frame
//   rd_done    : one-cycle pulse after the final word was accepted
//   bank_full  : per-bank full flags
//   overflow   : sticky, a write was dropped because its bank was full
//   addr_err   : sticky, a write had wr_addr >= MEM_DEPTH
module pingpong_frame_buf #(
  parameter int DATA_WIDTH = 18,
  parameter int N_CH       = 2,
  parameter int MEM_DEPTH  = 1200,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [N_CH*DATA_WIDTH-1:0]   wr_data,
  input  logic                         wr_last,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [N_CH*DATA_WIDTH-1:0]   rd_data,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic                         rd_last,
  output logic                         rd_done,
  output logic [1:0]                   bank_full,
  output logic                         overflow,
  output logic                         addr_err
);

  localparam int WORD_W = N_CH * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WORD_W-1:0]     mem [2][MEM_DEPTH];
  logic [ADDR_WIDTH-1:0] len [2];
  logic                  wr_bank;
  logic                  rd_bank;

  logic                  addr_ok;
  logic                  blocked;
  logic                  wr_accept;
  logic                  wr_close;
  logic                  xfer;
  logic                  release_bank;
  logic                  load;
  logic [ADDR_WIDTH-1:0] len_m1;
  logic [ADDR_WIDTH-1:0] rd_addr_nxt;
  logic [ADDR_WIDTH-1:0] raddr_p0;
  logic [1:0]            full_nxt;

  assign rd_valid     = (state == STREAM);
  assign len_m1       = len[rd_bank] - ADDR_WIDTH'(1);
  assign rd_last      = rd_valid && (rd_addr == len_m1);
  assign xfer         = rd_valid && rd_ready;
  assign release_bank = xfer && rd_last;

  // A bank being released by the reader in this cycle is already free for
  // the writer, so a beat that would otherwise be dropped is accepted.
  assign blocked   = bank_full[wr_bank] && !(release_bank && (rd_bank == wr_bank));
  assign addr_ok   = (wr_addr < DEPTH_A);
  assign wr_accept = wr_en && !blocked && addr_ok;
  // An out-of-range beat still closes its frame, with len clamped to MEM_DEPTH.
  assign wr_close  = wr_en && !blocked && wr_last;

  always_comb begin
    full_nxt = bank_full;
    if (release_bank) full_nxt[rd_bank] = 1'b0;
    if (wr_close)     full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bank_full[rd_bank]) state_nxt = FETCH;
      FETCH:   state_nxt = STREAM;
      STREAM:  if (release_bank) state_nxt = bank_full[~rd_bank] ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // stage 0: choose the next read address; the following word is prefetched
  // during each transfer so a frame streams without bubbles.
  assign rd_addr_nxt = rd_addr + ADDR_WIDTH'(1);
  assign raddr_p0    = (state == FETCH) ? '0 : rd_addr_nxt;
  assign load        = (state == FETCH) || (xfer && !rd_last);

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_bank][wr_addr] <= wr_data;
  end

  // stage 1: registered read word plus write/read bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
      len[0]    <= '0;
      len[1]    <= '0;
      overflow  <= 1'b0;
      addr_err  <= 1'b0;
      rd_done   <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
    end else begin
      rd_done   <= release_bank;
      bank_full <= full_nxt;
      if (wr_en && blocked)  overflow <= 1'b1;
      if (wr_en && !addr_ok) addr_err <= 1'b1;
      if (wr_close) begin
        len[wr_bank] <= addr_ok ? (wr_addr + ADDR_WIDTH'(1)) : DEPTH_A;
        wr_bank      <= ~wr_bank;
      end
      if (release_bank) rd_bank <= ~rd_bank;
      if (load) begin
        rd_addr <= raddr_p0;
        rd_data <= mem[rd_bank][raddr_p0];
      end
    end
  end

endmodule

// File: tb/tb_pingpong_frame_buf.sv
// tb_pingpong_frame_buf
//   Bench for pingpong_frame_buf with default parameters. A frame-level model
//   (bank contents, lengths, full flags, a reader countdown) predicts every
//   output each cycle; directed sequences add literal expectations.
module tb_pingpong_frame_buf;

  localparam int W     = 36;
  localparam int AW    = 11;
  localparam int DEPTH = 1200;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          wr_last;
  logic          rd_ready;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic [AW-1:0] rd_addr;
  logic          rd_last;
  logic          rd_done;
  logic [1:0]    bank_full;
  logic          overflow;
  logic          addr_err;

  pingpong_frame_buf dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
    .rd_last   (rd_last),
    .rd_done   (rd_done),
    .bank_full (bank_full),
    .overflow  (overflow),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] m_mem   [2][DEPTH];
  bit           m_known [2][DEPTH];
  int           m_len   [2];
  logic [1:0]   m_full;
  int           m_wbank, m_rbank;
  bit           m_busy;
  int           m_cnt, m_idx;
  bit           m_done, m_ovf, m_aerr;

  logic [W-1:0] got      [$];
  bit           got_last [$];
  int           got_cyc  [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 2'b00; m_len[0] = 0; m_len[1] = 0;
    m_wbank = 0; m_rbank = 0; m_busy = 0; m_cnt = 0; m_idx = 0;
    m_done = 0; m_ovf = 0; m_aerr = 0;
  endtask

  task automatic model_step();
    bit valid, last, xfer, rel, blocked, ok;
    logic [1:0] full_pre;
    valid    = m_busy && (m_cnt == 0);
    last     = valid && (m_idx == m_len[m_rbank] - 1);
    xfer     = valid && rd_ready;
    rel      = xfer && last;
    full_pre = m_full;
    blocked  = m_full[m_wbank] && !(rel && (m_rbank == m_wbank));
    ok       = (int'(wr_addr) < DEPTH);
    m_done   = rel;
    if (wr_en && blocked) m_ovf = 1;
    if (wr_en && !ok)     m_aerr = 1;
    // reader: a full bank shows its first word two cycles after it is seen
    if (m_busy && m_cnt > 0) m_cnt--;
    else if (!m_busy) begin
      if (full_pre[m_rbank]) begin m_busy = 1; m_cnt = 1; m_idx = 0; end
    end else if (xfer) begin
      if (!last) m_idx++;
      else begin
        m_full[m_rbank] = 1'b0;
        m_rbank ^= 1;
        if (full_pre[m_rbank]) begin m_busy = 1; m_cnt = 1; m_idx = 0; end
        else m_busy = 0;
      end
    end
    // writer
    if (wr_en && !blocked) begin
      if (ok) begin
        m_mem[m_wbank][int'(wr_addr)]   = wr_data;
        m_known[m_wbank][int'(wr_addr)] = 1;
      end
      if (wr_last) begin
        m_len[m_wbank]  = ok ? int'(wr_addr) + 1 : DEPTH;
        m_full[m_wbank] = 1'b1;
        m_wbank ^= 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else begin
        if (clk) begin
          model_step();
          cyc++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      bit ev, el;
      @(negedge clk);
      ev = reset && m_busy && (m_cnt == 0);
      el = ev && (m_idx == m_len[m_rbank] - 1);
      chk("rd_valid",  64'(rd_valid),  64'(ev));
      chk("rd_last",   64'(rd_last),   64'(el));
      chk("rd_done",   64'(rd_done),   64'(m_done));
      chk("bank_full", 64'(bank_full), 64'(m_full));
      chk("overflow",  64'(overflow),  64'(m_ovf));
      chk("addr_err",  64'(addr_err),  64'(m_aerr));
      if (ev) begin
        chk("rd_addr", 64'(rd_addr), 64'(m_idx));
        if (m_known[m_rbank][m_idx]) chk("rd_data", 64'(rd_data), 64'(m_mem[m_rbank][m_idx]));
      end
      if (!reset) begin
        chk("rst_rd_addr", 64'(rd_addr), 64'(0));
        chk("rst_rd_data", 64'(rd_data), 64'(0));
      end
      if (reset && rd_valid && rd_ready) begin
        got.push_back(rd_data);
        got_last.push_back(rd_last);
        got_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_last = 0;
  endtask

  task automatic write(input int a, input logic [W-1:0] d, input bit l);
    wr_en = 1; wr_addr = AW'(a); wr_data = d; wr_last = l;
    tick();
    idle_in();
  endtask

  task automatic do_reset();
    reset = 0;
    tick(); tick();
    reset = 1;
    tick();
  endtask

  task automatic wait_done(input int n, input int mode, input int budget);
    int seen = 0;
    int k = 0;
    while (seen < n && k < budget) begin
      case (mode)
        0:       rd_ready = 1;
        1:       rd_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: rd_ready = 1'($urandom % 2);
      endcase
      tick();
      k++;
      if (rd_done) seen++;
    end
    total++;
    if (seen < n) begin
      bad++;
      $display("FAIL wait_done seen=%0d want=%0d", seen, n);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] exp36 [7];
    int seq;
    reset = 0; rd_ready = 0;
    idle_in();
    repeat (3) tick();
    chk("reset_valid", 64'(rd_valid), 64'(0));
    chk("reset_full",  64'(bank_full), 64'(0));
    chk("reset_ovf",   64'(overflow), 64'(0));
    chk("reset_aerr",  64'(addr_err), 64'(0));
    chk("reset_data",  64'(rd_data), 64'(0));
    reset = 1;
    tick();

    // basic 5-word frame, latency and ordering
    rd_ready = 1;
    for (int i = 0; i < 5; i++) write(i, W'(32'h11 + i), i == 4);
    chk("t1_full0",  64'(bank_full), 64'(2'b01));
    chk("t1_val_c0", 64'(rd_valid), 64'(0));
    tick();
    chk("t1_val_c1", 64'(rd_valid), 64'(0));
    tick();
    chk("t1_val_c2", 64'(rd_valid), 64'(1));
    chk("t1_d0",     64'(rd_data), 64'h11);
    chk("t1_a0",     64'(rd_addr), 64'(0));
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("t1_data", 64'(rd_data), 64'(32'h11 + i));
      chk("t1_addr", 64'(rd_addr), 64'(i));
      chk("t1_last", 64'(rd_last), 64'(i == 4));
    end
    tick();
    chk("t1_done",  64'(rd_done), 64'(1));
    chk("t1_empty", 64'(bank_full), 64'(0));
    tick();
    chk("t1_done_pulse", 64'(rd_done), 64'(0));

    // same frame with stalls
    for (int i = 0; i < 5; i++) write(i, W'(32'h11 + i), i == 4);
    got.delete(); got_last.delete(); got_cyc.delete();
    wait_done(1, 1, 80);
    chk("t2_count", 64'(got.size()), 64'(5));
    for (int i = 0; i < 5 && i < got.size(); i++) chk("t2_order", 64'(got[i]), 64'(32'h11 + i));

    // both banks full, overflow, then drain with a one-cycle gap
    rd_ready = 0;
    for (int i = 0; i < 4; i++) write(i, W'(32'h30 + i), i == 3);
    for (int i = 0; i < 3; i++) write(i, W'(32'h40 + i), i == 2);
    write(0, W'(32'h55), 0);
    chk("t3_ovf",  64'(overflow), 64'(1));
    chk("t3_full", 64'(bank_full), 64'(2'b11));
    got.delete(); got_last.delete(); got_cyc.delete();
    wait_done(2, 0, 100);
    exp36[0] = 36'h30; exp36[1] = 36'h31; exp36[2] = 36'h32; exp36[3] = 36'h33;
    exp36[4] = 36'h40; exp36[5] = 36'h41; exp36[6] = 36'h42;
    chk("t3_count", 64'(got.size()), 64'(7));
    if (got.size() == 7) begin
      for (int i = 0; i < 7; i++) chk("t3_data", 64'(got[i]), 64'(exp36[i]));
      chk("t3_gap",     64'(got_cyc[4] - got_cyc[3]), 64'(2));
      chk("t3_nobubble", 64'(got_cyc[3] - got_cyc[0]), 64'(3));
    end

    // bad address, single-beat frame, bad-address close with stale words
    do_reset();
    rd_ready = 1;
    write(DEPTH, W'(32'hdead), 0);
    chk("t4_aerr", 64'(addr_err), 64'(1));
    chk("t4_full", 64'(bank_full), 64'(0));
    write(0, W'(32'h77), 1);
    got.delete(); got_last.delete(); got_cyc.delete();
    wait_done(1, 0, 20);
    chk("t4_single_n", 64'(got.size()), 64'(1));
    if (got.size() == 1) begin
      chk("t4_single_d", 64'(got[0]), 64'h77);
      chk("t4_single_l", 64'(got_last[0]), 64'(1));
    end
    write(DEPTH, W'(32'hbeef), 1);
    chk("t4_close_full", 64'(bank_full), 64'(2'b10));
    got.delete(); got_last.delete(); got_cyc.delete();
    wait_done(1, 0, 1300);
    chk("t4_len", 64'(got.size()), 64'(DEPTH));
    if (got.size() == DEPTH) begin
      chk("t4_stale0", 64'(got[0]), 64'h40);
      chk("t4_stale3", 64'(got[3]), 64'h14);
      chk("t4_lastl",  64'(got_last[DEPTH-1]), 64'(1));
      chk("t4_notl",   64'(got_last[DEPTH-2]), 64'(0));
    end

    // release and blocked write in the same cycle
    do_reset();
    rd_ready = 0;
    write(0, W'(32'h51), 0);
    write(1, W'(32'h52), 1);
    write(0, W'(32'h61), 0);
    write(1, W'(32'h62), 1);
    tick();
    rd_ready = 1;
    got.delete(); got_last.delete(); got_cyc.delete();
    tick();
    write(0, W'(32'h99), 1);
    chk("t5_ovf",  64'(overflow), 64'(0));
    chk("t5_full", 64'(bank_full), 64'(2'b11));
    wait_done(2, 0, 40);
    chk("t5_count", 64'(got.size()), 64'(5));
    if (got.size() == 5) begin
      chk("t5_w0", 64'(got[0]), 64'h51);
      chk("t5_w2", 64'(got[2]), 64'h61);
      chk("t5_new", 64'(got[4]), 64'h99);
    end

    // asynchronous reset in the middle of a stream
    do_reset();
    rd_ready = 1;
    for (int i = 0; i < 8; i++) write(i, W'(32'h80 + i), i == 7);
    tick(); tick(); tick();
    chk("t6_streaming", 64'(rd_valid), 64'(1));
    #2 reset = 0;
    #1;
    chk("t6_valid", 64'(rd_valid), 64'(0));
    chk("t6_last",  64'(rd_last), 64'(0));
    chk("t6_done",  64'(rd_done), 64'(0));
    chk("t6_addr",  64'(rd_addr), 64'(0));
    chk("t6_data",  64'(rd_data), 64'(0));
    chk("t6_full",  64'(bank_full), 64'(0));
    tick();
    reset = 1;
    tick();
    chk("t6_idle", 64'(rd_valid), 64'(0));
    for (int i = 0; i < 3; i++) write(i, W'(32'ha0 + i), i == 2);
    got.delete(); got_last.delete(); got_cyc.delete();
    wait_done(1, 0, 20);
    chk("t6_count", 64'(got.size()), 64'(3));
    if (got.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("t6_data_rd", 64'(got[i]), 64'(32'ha0 + i));
    end

    // randomized traffic, checked by the model every cycle
    seq = 0;
    for (int k = 0; k < 3000; k++) begin
      int r;
      bit badaddr;
      rd_ready = (($urandom % 4) != 0);
      wr_en    = (($urandom % 3) != 0);
      r        = int'($urandom % 64);
      badaddr  = (r == 0);
      if (badaddr)    wr_addr = AW'(DEPTH + int'($urandom % 8));
      else if (r < 6) wr_addr = AW'($urandom % 16);
      else            wr_addr = AW'(seq);
      wr_data  = W'({$urandom, $urandom});
      wr_last  = !badaddr && ((($urandom % 8) == 0) || (seq >= 14));
      tick();
      if (wr_en) seq = wr_last ? 0 : (seq + 1) % 16;
    end
    idle_in();
    rd_ready = 1;
    begin
      int k = 0;
      while ((bank_full != 2'b00 || rd_valid) && k < 400) begin
        tick();
        k++;
      end
      total++;
      if (bank_full != 2'b00 || rd_valid) begin
        bad++;
        $display("FAIL drain bank_full=%b rd_valid=%b", bank_full, rd_valid);
      end
    end
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
